// File: rtl/dbus_pkg.sv
// Shared types for the two-port data-bus arbiter: FSM states, requester ids,
// the latched request payload and default sizing.
package dbus_pkg;

    localparam int DBUS_ADDR_W  = 32;
    localparam int DBUS_DATA_W  = 32;
    localparam int DBUS_MASK_W  = DBUS_DATA_W / 8;
    localparam int DBUS_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                   we;
        logic [DBUS_ADDR_W-1:0] addr;
        logic [DBUS_DATA_W-1:0] wdata;
        logic [DBUS_MASK_W-1:0] mask;
    } req_t;

    function automatic req_id_t other_port(req_id_t id);
        return (id == REQ_C) ? REQ_D : REQ_C;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of the core, DMA and memory-side signals of data_bus_arbiter.
// slave = arbiter view, master = environment (core, DMA, memory) view.
interface data_bus_arbiter_if
    import dbus_pkg::*;
#(
    parameter int ADDR_W = DBUS_ADDR_W,
    parameter int DATA_W = DBUS_DATA_W
);
    localparam int MASK_W = DATA_W / 8;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [MASK_W-1:0] c_mask;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_mask;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_mask,
        output c_ack, c_rdata, c_stall,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        output d_ack, d_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata, mem_ready,
        output err
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_mask,
        input  c_ack, c_rdata, c_stall,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        input  d_ack, d_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_rdata, mem_ready,
        input  err
    );

endinterface

// File: rtl/dbus_rr_picker.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the port that did not win last time.
module dbus_rr_picker
    import dbus_pkg::*;
(
    input  logic    c_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        grant_valid = c_req | d_req;
        grant_id    = REQ_C;
        if (c_req && d_req) begin
            grant_id = other_port(last_grant);
        end else if (d_req) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one data-memory port between the core (C) and a DMA/debug master (D).
// Define ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES with an err pulse.
module data_bus_arbiter
    import dbus_pkg::*;
#(
    parameter int ADDR_W         = DBUS_ADDR_W,
    parameter int DATA_W         = DBUS_DATA_W,
    parameter int TIMEOUT_CYCLES = DBUS_TIMEOUT
) (
    input logic               clk,
    input logic               reset,
    data_bus_arbiter_if.slave bus
);

    // The latched payload is a package struct, so bus widths must match it.
    if (ADDR_W != DBUS_ADDR_W || DATA_W != DBUS_DATA_W || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("data_bus_arbiter: widths must match dbus_pkg and TIMEOUT_CYCLES must be >= 1");
    end

    state_t                 state_q, state_d;
    req_id_t                winner_q, winner_d;
    req_id_t                last_grant_q, last_grant_d;
    logic                   mem_cs_q, mem_cs_d;
    req_t                   req_q, req_d;
    logic [DBUS_DATA_W-1:0] cap_q, cap_d;

    logic    grant_valid;
    req_id_t grant_id;
    req_t    c_pkt, d_pkt;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
`endif

    assign c_pkt = '{we: bus.c_we, addr: bus.c_addr, wdata: bus.c_wdata, mask: bus.c_mask};
    assign d_pkt = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, mask: bus.d_mask};

    dbus_rr_picker u_picker (
        .c_req       (bus.c_req),
        .d_req       (bus.d_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            winner_q     <= REQ_C;
            last_grant_q <= REQ_D;
            mem_cs_q     <= 1'b0;
            req_q        <= '0;
            cap_q        <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            mem_cs_q     <= mem_cs_d;
            req_q        <= req_d;
            cap_q        <= cap_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        mem_cs_d     = mem_cs_q;
        req_d        = req_q;
        cap_d        = cap_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        abort_d      = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = ACCESS;
                    winner_d = grant_id;
                    mem_cs_d = 1'b1;
                    req_d    = (grant_id == REQ_C) ? c_pkt : d_pkt;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
                    abort_d  = 1'b0;
`endif
                end
            end
            ACCESS: begin
                // mem_ready beats the watchdog when both land in the same cycle
                if (bus.mem_ready) begin
                    state_d  = RESP;
                    mem_cs_d = 1'b0;
                    req_d.we = 1'b0;
                    cap_d    = bus.mem_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = RESP;
                    mem_cs_d = 1'b0;
                    req_d.we = 1'b0;
                    cap_d    = '0;
                    abort_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = winner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.c_ack   = 1'b0;
        bus.c_rdata = '0;
        bus.d_ack   = 1'b0;
        bus.d_rdata = '0;
        bus.err     = 1'b0;
        if (state_q == RESP) begin
            if (winner_q == REQ_C) begin
                bus.c_ack   = 1'b1;
                bus.c_rdata = cap_q;
            end else begin
                bus.d_ack   = 1'b1;
                bus.d_rdata = cap_q;
            end
`ifdef ARB_TIMEOUT_EN
            bus.err = abort_q;
`endif
        end
    end

    assign bus.c_stall   = bus.c_req & ~bus.c_ack;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = req_q.we;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_mask  = req_q.mask;

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Arbitrates one shared data-memory port between two requesters: the core load/store unit (port C) and a DMA/debug master (port D). It latches the winning request, drives a registered memory strobe, waits for memory ready, then returns read data with a one-cycle ack. It provides a combinational stall so the single-cycle core freezes its PC while its access is outstanding.

Parameters:
ADDR_W, 32, address width, both ports and memory
DATA_W, 32, data width; mask width = DATA_W/8
TIMEOUT_CYCLES, 16, max cycles in ACCESS before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  core request; held with payload until c_ack
c_we  in  1  core write (1) / read (0)
c_addr  in  ADDR_W  core byte address
c_wdata  in  DATA_W  core write data
c_mask  in  DATA_W/8  core byte-enable mask
c_ack  out  1  one-cycle completion pulse to core
c_rdata  out  DATA_W  read data, valid while c_ack=1
c_stall  out  1  c_req & ~c_ack, combinational
d_req, d_we, d_addr, d_wdata, d_mask  in  same widths as core  DMA request set
d_ack  out  1  one-cycle completion pulse to DMA
d_rdata  out  DATA_W  read data, valid while d_ack=1
mem_cs  out  1  memory chip select, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_mask  out  DATA_W/8  latched mask
mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completes access this cycle
err  out  1  one-cycle abort pulse, coincident with the ack (timeout build only)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; last_grant=D, so the core wins the first tie. mem_cs drops immediately, even mid-ACCESS; the in-flight access is abandoned and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if neither request is high, stay in IDLE. If only one is high, grant it. If both are high, grant the port not equal to last_grant. Latch we/addr/wdata/mask of the winner into mem_* and set mem_cs=1, all on the same edge, then go to ACCESS.
- ACCESS: mem_* outputs held stable. When mem_ready=1, capture mem_rdata (capture writes too; data ignored), clear mem_cs and mem_we on the same edge, and go to RESP.
- RESP: assert the winner's ack for exactly one cycle, with rdata driven from the capture register. Set last_grant=winner, then go to IDLE.
- Minimum latency: req seen in IDLE at cycle 0, mem_cs high at cycle 1, mem_ready at cycle 1, ack at cycle 2. Each memory wait cycle adds one cycle.
- Requests arriving in ACCESS or RESP are not sampled; they wait for IDLE.
- A request still high in the cycle after its ack is a new request; it is arbitrated fairly against the other port.
- Fairness: with both ports requesting continuously, grants strictly alternate C, D, C, D.
- The non-granted port's ack and rdata remain 0.
- c_rdata and d_rdata are 0 whenever the corresponding ack is 0.
- Requester dropping req before its ack is a protocol violation; the arbiter still completes and acks.
- mem_ready outside ACCESS is ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: an ACCESS-cycle counter clears on entry to ACCESS. If it reaches TIMEOUT_CYCLES with no mem_ready, mem_cs is cleared, the capture register is loaded with 0, and the FSM goes to RESP. In RESP, ack and err are pulsed together. mem_ready in the same cycle the counter hits the limit wins, with a normal completion and err=0.
- Undefined: no counter; ACCESS waits indefinitely; err tied to 0.

Decomposition:
- Package dbus_pkg: state enum (IDLE, ACCESS, RESP); requester id enum (REQ_C, REQ_D); packed request struct {we, addr, wdata, mask}; default TIMEOUT constant.
- One sub-module, dbus_rr_picker: combinational; inputs c_req, d_req, last_grant; outputs grant_valid, grant_id.

Test Plan:
- Reset mid-ACCESS: c_req=1, hold mem_ready=0, assert reset=0 in cycle 2 -> mem_cs=0 immediately; no c_ack; after release, state is IDLE.
- Single core read: c_req=1, c_addr=0x0000_0010, mem_ready=1 with mem_rdata=0xDEAD_BEEF at cycle 1 -> c_ack=1 at cycle 2 with c_rdata=0xDEAD_BEEF; c_stall=1 in cycles 0-1, 0 at cycle 2.
- Simultaneous requests after reset: c_req=d_req=1 held, mem_ready always 1 -> grant order C, D, C, D; acks at cycles 2, 5, 8, 11.
- Wait states on a DMA write: d_we=1, d_addr=0x20, d_wdata=0x1234_5678, d_mask=4'b0011, mem_ready after 3 wait cycles -> mem_* stable for 4 cycles; d_ack one cycle later; d_rdata ignored.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): c_req=1, mem_ready never asserted -> mem_cs high 4 cycles; then c_ack=1, err=1, c_rdata=0.
- Late mem_ready versus timeout limit: mem_ready=1 exactly at the limit cycle -> normal ack, err=0, rdata equals mem_rdata.
